// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: instruction, data and shared-memory sram-like handshake bundle
interface sram_like_arbiter_if;
  logic        inst_request, inst_write;
  logic [1:0]  inst_size;
  logic [31:0] inst_address, inst_write_data, inst_read_data;
  logic [3:0]  inst_write_strobe;
  logic        inst_address_ready, inst_data_ready;
  logic        data_request, data_write;
  logic [1:0]  data_size;
  logic [31:0] data_address, data_write_data, data_read_data;
  logic [3:0]  data_write_strobe;
  logic        data_address_ready, data_data_ready;
  logic        mem_request, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_strobe;
  logic        mem_address_ready, mem_data_ready;
  modport slave (
    input  inst_request, inst_write, inst_size, inst_address, inst_write_data, inst_write_strobe,
    output inst_read_data, inst_address_ready, inst_data_ready,
    input  data_request, data_write, data_size, data_address, data_write_data, data_write_strobe,
    output data_read_data, data_address_ready, data_data_ready,
    output mem_request, mem_write, mem_size, mem_address, mem_write_data, mem_write_strobe,
    input  mem_read_data, mem_address_ready, mem_data_ready
  );
  modport master (
    output inst_request, inst_write, inst_size, inst_address, inst_write_data, inst_write_strobe,
    input  inst_read_data, inst_address_ready, inst_data_ready,
    output data_request, data_write, data_size, data_address, data_write_data, data_write_strobe,
    input  data_read_data, data_address_ready, data_data_ready,
    input  mem_request, mem_write, mem_size, mem_address, mem_write_data, mem_write_strobe,
    output mem_read_data, mem_address_ready, mem_data_ready
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like port between inst and data masters, data has priority
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clock_i,
  input logic reset_i,
  sram_like_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  typedef enum logic {INST = 1'b0, DATA = 1'b1} id_e;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  id_e           id_q [MAX_OUTSTANDING];
  logic          lock_valid_q, lock_valid_d;
  id_e           lock_id_q, lock_id_d, grant, head;
  logic          can_issue, req_sel, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  // A presented request holds the grant until accepted or withdrawn; otherwise data wins
  always_comb begin
    can_issue = count_q < CW'(MAX_OUTSTANDING);
    grant = lock_valid_q ? lock_id_q : (bus.data_request || !bus.inst_request ? DATA : INST);
    req_sel = grant == DATA ? bus.data_request : bus.inst_request;
    push = bus.mem_request && bus.mem_address_ready;
    pop = reset_i && bus.mem_data_ready && count_q != '0;
    head = id_q[rd_ptr_q];
    count_d = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
    lock_valid_d = bus.mem_request && !bus.mem_address_ready;
    lock_id_d = bus.mem_request ? grant : lock_id_q;
  end
  assign bus.mem_request        = reset_i && can_issue && req_sel;
  assign bus.mem_write          = grant == DATA ? bus.data_write : bus.inst_write;
  assign bus.mem_size           = grant == DATA ? bus.data_size : bus.inst_size;
  assign bus.mem_address        = grant == DATA ? bus.data_address : bus.inst_address;
  assign bus.mem_write_data     = grant == DATA ? bus.data_write_data : bus.inst_write_data;
  assign bus.mem_write_strobe   = grant == DATA ? bus.data_write_strobe : bus.inst_write_strobe;
  assign bus.inst_address_ready = push && grant == INST;
  assign bus.data_address_ready = push && grant == DATA;
  assign bus.inst_data_ready    = pop && head == INST;
  assign bus.data_data_ready    = pop && head == DATA;
  assign bus.inst_read_data     = bus.mem_read_data;
  assign bus.data_read_data     = bus.mem_read_data;
  // FIFO occupancy, pointers and the presented-request lock
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q <= INST;
    end else begin
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q <= lock_id_d;
    end
  end
  // Owner ID of every accepted request, read back in acceptance order
  always_ff @(posedge clock_i) begin
    if (push) id_q[wr_ptr_q] <= grant;
  end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one sram-like memory port (request / address_ready / data_ready handshake) between the instruction-fetch requester and the data requester of the cpu_core. Handshake semantics are identical on both sides, so it sits between the pipeline stages and the bridge or cache without changes to either.
Data requests have fixed priority. Up to MAX_OUTSTANDING accepted requests may be in flight. Responses are returned in order and routed back to the originating master through an internal ID FIFO.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (ID FIFO depth, power of two, >=1)

Ports:
clock  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-low (0 = reset)
inst_request / inst_write  input  1 / 1  instruction master request / write flag
inst_size  input  2  transfer size
inst_address / inst_write_data  input  32 / 32  address, store data
inst_write_strobe  input  4  byte strobes
inst_read_data  output  32  response data
inst_address_ready / inst_data_ready  output  1 / 1  request accepted / response valid
data_*  same nine signals as inst_*, data master
mem_request / mem_write  output  1 / 1  to shared slave
mem_size  output  2  to shared slave
mem_address / mem_write_data  output  32 / 32  to shared slave
mem_write_strobe  output  4  to shared slave
mem_read_data  input  32  from slave
mem_address_ready / mem_data_ready  input  1 / 1  from slave

Behaviour:
- Reset (reset==0 at posedge): ID FIFO empty (count=0, rd/wr pointers 0), lock_valid=0.
- While reset==0, mem_request, inst_address_ready, data_address_ready, inst_data_ready and data_data_ready are all 0.
- can_issue = (count < MAX_OUTSTANDING).
  - Evaluated on registered count only; a same-cycle pop does not free a slot.
- Grant selection (combinational), in this order:
  - If lock_valid: grant = lock_id.
  - Else if data_request: grant = DATA.
  - Else if inst_request: grant = INST.
  - Else: no grant.
- mem_request = can_issue && granted master's request. mem_write, mem_size, mem_address, mem_write_data and mem_write_strobe are muxed from the granted master (data master when no grant).
- Only the granted master sees address_ready: granted_address_ready = mem_address_ready && mem_request. The other master's address_ready is 0.
- Address handshake (mem_request && mem_address_ready): push grant ID (0=INST, 1=DATA) into the FIFO.
- Lock:
  - mem_request high without mem_address_ready: lock_valid<=1, lock_id<=grant. A presented request is never pre-empted, even by a later data request.
  - Handshake completes: lock_valid<=0.
  - Locked master drops its request: lock_valid<=0 next cycle and arbitration resumes. Requests may be withdrawn only when not locked; a locked master must hold its request.
  - can_issue==0: mem_request=0 and the lock is not set.
- Response (mem_data_ready, count>0): pop the head ID.
  - Assert data_ready only to that master, same cycle (zero latency).
  - inst_read_data and data_read_data both = mem_read_data unconditionally; qualify with data_ready.
- mem_data_ready with count==0 is a slave protocol error: ignored, no pop, neither data_ready asserted.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- Responses of the same master stay ordered. Cross-master ordering follows acceptance order.
- Exception flush in the pipeline does not touch this block. A master that must drop a reply does so itself, e.g. if-stage instruction_ignore; the reply is still delivered.
- Reset mid-transaction: FIFO and lock cleared immediately. Any slave response arriving after reset release with count==0 is discarded per the rule above.

Test Plan:
- Contention: inst_request=data_request=1, mem_address_ready=1 every cycle -> data accepted cycles 0,1 (FIFO full, MAX_OUTSTANDING=2); mem_request=0 until a response; inst never granted while data keeps requesting unlocked.
- Lock: inst_request alone, mem_address_ready=0 for 3 cycles, data_request rises at cycle 1 -> mem_address stays inst_address until ready; inst accepted, then data granted next cycle.
- Routing: accept INST@0x bfc00000, then DATA@0x00001000; two mem_data_ready pulses with 0x11111111, 0x22222222 -> inst_data_ready with 0x11111111, then data_data_ready with 0x22222222; the other data_ready stays 0.
- Full + same-cycle pop: count=2, mem_data_ready=1 and a new request -> no acceptance that cycle (mem_request=0); accepted next cycle; count sequence 2,1,2.
- Spurious response: count=0, mem_data_ready=1 -> no data_ready to either master, count stays 0.
- Reset mid-flight: two outstanding, drive reset=0 one cycle -> all ready outputs 0 during reset; count=0 after; next request accepted with FIFO head pointer 0.
